// File: rtl/mod_arbiter.sv
// mod_arbiter: round-robin sharing of one multi-cycle modulo unit among NUM_REQ requesters
module mod_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic [CNT_W-1:0]         last_cycles,
  output logic                     busy,
  output logic                     mod_start,
  output logic [WIDTH-1:0]         mod_a,
  output logic [WIDTH-1:0]         mod_b,
  input  logic [WIDTH-1:0]         mod_result,
  input  logic                     mod_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, id, win_id, nxt_ptr;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [WIDTH-1:0] win_a, win_b;
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v % NUM_REQ);
  endfunction
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end
  // scanning from the far end lets the requester nearest rr_ptr win last
  always_comb begin
    win_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[wrap(int'(rr_ptr) + k)]) win_id = wrap(int'(rr_ptr) + k);
  end
  assign win_a = a_arr[win_id];
  assign win_b = b_arr[win_id];
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign nxt_ptr = id == IDW'(NUM_REQ - 1) ? '0 : id + 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      id <= '0;
      cnt <= '0;
      gnt <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
      last_cycles <= '0;
      busy <= 1'b0;
      mod_start <= 1'b0;
      mod_a <= '0;
      mod_b <= '0;
    end else begin
      gnt <= '0;
      mod_start <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state <= ISSUE;
          busy <= 1'b1;
          id <= win_id;
          mod_a <= win_a;
          mod_b <= win_b;
          gnt <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          mod_start <= |win_b;
        end
        ISSUE: if (|mod_b) begin
          state <= WAIT;
          cnt <= '0;
        end else begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_id <= id;
          rsp_result <= '0;
          rsp_err <= 1'b1;
          last_cycles <= '0;
        end
        WAIT: if (mod_done) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_id <= id;
          rsp_result <= mod_result;
          rsp_err <= 1'b0;
          last_cycles <= cnt_inc;
        end else cnt <= cnt_inc;
        RESP: begin
          state <= IDLE;
          busy <= 1'b0;
          rr_ptr <= nxt_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_arbiter.sv
// tb_mod_arbiter: scoreboard bench with a behavioural modulo unit and a CNT_W=4 twin
module tb_mod_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0] mod_result;
  logic mod_done, m_done, x_done;
  logic [N-1:0] gnt, d4_gnt;
  logic rsp_valid, rsp_err, busy, mod_start;
  logic d4_rsp_valid, d4_rsp_err, d4_busy, d4_mod_start;
  logic [1:0] rsp_id, d4_rsp_id;
  logic [W-1:0] rsp_result, mod_a, mod_b, d4_rsp_result, d4_mod_a, d4_mod_b;
  logic [15:0] last_cycles;
  logic [3:0] d4_last;
  assign mod_done = m_done | x_done;
  mod_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .last_cycles(last_cycles), .busy(busy), .mod_start(mod_start), .mod_a(mod_a),
    .mod_b(mod_b), .mod_result(mod_result), .mod_done(mod_done));
  mod_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b), .gnt(d4_gnt),
    .rsp_valid(d4_rsp_valid), .rsp_id(d4_rsp_id), .rsp_result(d4_rsp_result),
    .rsp_err(d4_rsp_err), .last_cycles(d4_last), .busy(d4_busy), .mod_start(d4_mod_start),
    .mod_a(d4_mod_a), .mod_b(d4_mod_b), .mod_result(mod_result), .mod_done(mod_done));
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // behavioural modulo unit: done high for done_len cycles starting lat cycles after start
  int lat = 3;
  int done_len = 1;
  int k;
  logic active;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      m_done <= 1'b0;
      k <= 0;
      mod_result <= '0;
    end else if (mod_start) begin
      active <= 1'b1;
      k <= 1;
      mod_result <= mod_b != 0 ? mod_a % mod_b : 0;
      m_done <= lat == 1;
    end else if (active) begin
      k <= k + 1;
      m_done <= (k + 1 >= lat) && (k + 1 < lat + done_len);
      if (k + 1 >= lat + done_len) active <= 1'b0;
    end
  end
  typedef struct { int id; logic [31:0] a; logic [31:0] b; } gnt_t;
  typedef struct { int id; logic [31:0] res; logic err; int cyc; int cyc4; int lat; } rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];
  gnt_t g;
  rsp_t r;
  int cyc = 0;
  int gnt_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (reset) begin
    if (mod_start) check("start_with_gnt", |gnt, 1);
    if (|gnt) begin
      check("gnt_onehot", $countones(gnt), 1);
      check("gnt_expected", gq.size() != 0, 1);
      if (gq.size() != 0) begin
        g = gq.pop_front();
        check("gnt_id", gnt, 1 << g.id);
        check("mod_start", mod_start, g.b != 0);
        check("mod_a", mod_a, g.a);
        check("mod_b", mod_b, g.b);
      end
      gnt_cyc = cyc;
    end
    if (rsp_valid) begin
      check("rsp_expected", rq.size() != 0, 1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        check("rsp_id", rsp_id, r.id);
        check("rsp_result", rsp_result, r.res);
        check("rsp_err", rsp_err, r.err);
        check("last_cycles", last_cycles, r.cyc);
        check("last_cycles_sat", d4_last, r.cyc4);
        check("rsp_latency", cyc - gnt_cyc, r.lat);
        check("twin_rsp", d4_rsp_valid, 1);
      end
    end
  end
  logic [31:0] a_tab [N];
  logic [31:0] b_tab [N];
  int m_ptr = 0;
  task automatic serve(input logic [N-1:0] mask, input int n, input int l);
    int w, seen, t;
    logic [31:0] ea, eb;
    lat = l;
    for (int j = 0; j < n; j++) begin
      w = -1;
      for (int s = 0; s < N; s++) if (w < 0 && mask[(m_ptr + s) % N]) w = (m_ptr + s) % N;
      ea = a_tab[w];
      eb = b_tab[w];
      gq.push_back('{w, ea, eb});
      rq.push_back('{w, eb != 0 ? ea % eb : 0, eb == 0, eb == 0 ? 0 : l,
                     eb == 0 ? 0 : (l > 15 ? 15 : l), eb == 0 ? 1 : l + 1});
      m_ptr = (w + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_tab[i];
      req_b[i*W +: W] = b_tab[i];
    end
    req = mask;
    seen = 0;
    t = 0;
    while (seen < n && t < n * (l + 10)) begin
      @(negedge clk);
      t++;
      if (|gnt) seen++;
    end
    req = '0;
    check("grants_seen", seen, n);
    t = 0;
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("idle_after", busy, 0);
    check("rsp_drained", rq.size(), 0);
  endtask
  task automatic chk_zero(input string tag);
    check({tag, "_ctl"}, {gnt, rsp_valid, rsp_id, rsp_err, busy, mod_start, last_cycles}, 0);
    check({tag, "_dat"}, {rsp_result, mod_a}, 0);
    check({tag, "_b"}, {mod_b, d4_last, d4_busy}, 0);
  endtask
  initial begin
    int t;
    req = '0;
    req_a = '0;
    req_b = '0;
    x_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    a_tab = '{10, 17, 24, 31};
    b_tab = '{3, 3, 3, 3};
    serve(4'b1111, 5, 3);
    a_tab[2] = 17;
    b_tab[2] = 5;
    serve(4'b0100, 1, 4);
    a_tab[1] = 50;
    b_tab[1] = 6;
    a_tab[3] = 23;
    b_tab[3] = 4;
    serve(4'b1010, 2, 2);
    a_tab[1] = 9;
    b_tab[1] = 0;
    serve(4'b0010, 1, 3);
    a_tab[0] = 100;
    b_tab[0] = 7;
    serve(4'b0001, 1, 40);
    @(negedge clk);
    x_done = 1'b1;
    @(negedge clk);
    x_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_ignored", busy, 0);
    done_len = 2;
    a_tab[2] = 32'hFFFF_FFFF;
    b_tab[2] = 10;
    serve(4'b0100, 1, 5);
    done_len = 1;
    lat = 30;
    a_tab[3] = 77;
    b_tab[3] = 5;
    req_a[3*W +: W] = a_tab[3];
    req_b[3*W +: W] = b_tab[3];
    gq.push_back('{3, a_tab[3], b_tab[3]});
    req = 4'b1000;
    t = 0;
    while (!gnt[3] && t < 20) begin
      @(negedge clk);
      t++;
    end
    req = '0;
    check("drop_gnt_seen", gnt[3], 1);
    repeat (5) @(negedge clk);
    check("drop_in_wait", busy, 1);
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    repeat (40) @(negedge clk);
    check("idle_after_reset", busy, 0);
    a_tab[0] = 45;
    b_tab[0] = 8;
    a_tab[3] = 64;
    b_tab[3] = 9;
    serve(4'b1001, 2, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
